// File: rtl/clkgate_ctrl.sv
// rtl/clkgate_ctrl.sv - idle-detect clock_en controller for the interleaver clock gate
// Optional gated-cycle statistics counter enabled by defining CLKGATE_STATS_EN.
module clkgate_ctrl #(
    parameter int IDLE_CYCLES = 16,
    parameter int WAKE_CYCLES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             busy,
    output logic             clock_en,
    output logic             gated
`ifdef CLKGATE_STATS_EN
    ,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] gated_cycles
`endif
);

    localparam int IW = $clog2(IDLE_CYCLES + 1);
    localparam int WW = $clog2(WAKE_CYCLES + 1);
    localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES - 1);
    localparam logic [WW-1:0] WAKE_MAX = WW'(WAKE_CYCLES - 1);

    if (IDLE_CYCLES < 1 || WAKE_CYCLES < 1 || CNT_W < 1) begin : g_bad_params
        $error("clkgate_ctrl: IDLE_CYCLES, WAKE_CYCLES and CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_GATED = 2'd2,
        ST_WAKE  = 2'd3
    } state_t;

    state_t          state;
    logic [IW-1:0]   idle_cnt;
    logic [WW-1:0]   wake_cnt;
    logic            idle;

    assign idle = !busy && !req_valid;

    // Outputs are loaded alongside the state so they never toggle while clk_in is low.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state     <= ST_WAKE;
            wake_cnt  <= '0;
            idle_cnt  <= '0;
            clock_en  <= 1'b1;
            req_ready <= 1'b0;
            gated     <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (idle) begin
                        if (idle_cnt == IDLE_MAX) begin
                            state     <= ST_DRAIN;
                            idle_cnt  <= '0;
                            req_ready <= 1'b0;
                        end else begin
                            idle_cnt <= idle_cnt + 1'b1;
                        end
                    end else begin
                        idle_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (req_valid || busy) begin
                        state     <= ST_RUN;
                        req_ready <= 1'b1;
                    end else begin
                        state    <= ST_GATED;
                        clock_en <= 1'b0;
                        gated    <= 1'b1;
                    end
                end
                ST_GATED: begin
                    // busy comes from the frozen domain, so only a request can wake us.
                    if (req_valid) begin
                        state    <= ST_WAKE;
                        wake_cnt <= '0;
                        clock_en <= 1'b1;
                        gated    <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (wake_cnt == WAKE_MAX) begin
                        state     <= ST_RUN;
                        idle_cnt  <= '0;
                        req_ready <= 1'b1;
                    end else begin
                        wake_cnt <= wake_cnt + 1'b1;
                    end
                end
                default: begin
                    state     <= ST_WAKE;
                    wake_cnt  <= '0;
                    clock_en  <= 1'b1;
                    req_ready <= 1'b0;
                    gated     <= 1'b0;
                end
            endcase
        end
    end

`ifdef CLKGATE_STATS_EN
    always_ff @(posedge clk_in) begin
        if (rst || clr_stats) begin
            gated_cycles <= '0;
        end else if (state == ST_GATED && !(&gated_cycles)) begin
            gated_cycles <= gated_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// tb/tb_clkgate_ctrl.sv - self-checking bench for clkgate_ctrl
module tb_clkgate_ctrl;

    localparam int IDLE = 4;
    localparam int WAKE = 2;
    localparam int CW   = 4;

    logic          clk_in    = 1'b0;
    logic          rst       = 1'b1;
    logic          req_valid = 1'b0;
    logic          busy      = 1'b0;
    logic          clr_stats = 1'b0;
    logic          req_ready;
    logic          clock_en;
    logic          gated;
    logic [CW-1:0] gated_cycles;

    always #5 clk_in = ~clk_in;

    clkgate_ctrl #(
        .IDLE_CYCLES (IDLE),
        .WAKE_CYCLES (WAKE),
        .CNT_W       (CW)
    ) dut (
        .clk_in       (clk_in),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .busy         (busy),
        .clock_en     (clock_en),
        .gated        (gated)
`ifdef CLKGATE_STATS_EN
        ,
        .clr_stats    (clr_stats),
        .gated_cycles (gated_cycles)
`endif
    );

`ifndef CLKGATE_STATS_EN
    assign gated_cycles = '0;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model: the clock is either stopped, counting down to readiness,
    // draining for one edge, or running with a tally of consecutive idle edges.
    bit m_stopped;
    int m_wake_left;
    bit m_draining;
    int m_idle_run;
    int m_stat;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit quiet;
        quiet = !busy && !req_valid;
        if (rst) begin
            m_stopped = 0; m_wake_left = WAKE; m_draining = 0; m_idle_run = 0; m_stat = 0;
            return;
        end
        if (clr_stats) m_stat = 0;
        else if (m_stopped && m_stat < (1 << CW) - 1) m_stat++;
        if (m_stopped) begin
            if (req_valid) begin
                m_stopped = 0;
                m_wake_left = WAKE;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
            m_idle_run = 0;
        end else if (m_draining) begin
            m_draining = 0;
            if (quiet) m_stopped = 1;
        end else if (quiet) begin
            m_idle_run++;
            if (m_idle_run == IDLE) begin
                m_draining = 1;
                m_idle_run = 0;
            end
        end else begin
            m_idle_run = 0;
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic b, input logic c);
        rst = r; req_valid = v; busy = b; clr_stats = c;
        @(posedge clk_in);
        model_step();
        #1;
        check("model clock_en", int'(clock_en), int'(!m_stopped));
        check("model req_ready", int'(req_ready), int'(!m_stopped && m_wake_left == 0 && !m_draining));
        check("model gated", int'(gated), int'(m_stopped));
`ifdef CLKGATE_STATS_EN
        check("model gated_cycles", int'(gated_cycles), m_stat);
`endif
    endtask

    task automatic expect3(input string name, input logic en, input logic rdy, input logic g);
        check({name, " clock_en"}, int'(clock_en), int'(en));
        check({name, " req_ready"}, int'(req_ready), int'(rdy));
        check({name, " gated"}, int'(gated), int'(g));
    endtask

    typedef struct {
        logic r, v, b;
        logic en, rdy, g;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic v, logic b, logic en, logic rdy, logic g);
        vec_t x;
        x.r = r; x.v = v; x.b = b; x.en = en; x.rdy = rdy; x.g = g;
        return x;
    endfunction

    initial begin
        m_stopped = 0; m_wake_left = WAKE; m_draining = 0; m_idle_run = 0; m_stat = 0;

        // Reset, wake-from-reset, idle timeout, wake, drain abort, busy on threshold
        for (int i = 0; i < 3; i++) tbl.push_back(mk(1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));
        for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 0));

        foreach (tbl[i]) begin
            cycle(tbl[i].r, tbl[i].v, tbl[i].b, 1'b0);
            expect3($sformatf("vec%0d", i), tbl[i].en, tbl[i].rdy, tbl[i].g);
        end

        // Long busy stretch never gates
        for (int i = 0; i < 100; i++) begin
            cycle(0, 0, 1, 0);
            check("busy hold clock_en", int'(clock_en), 1);
        end

        // Reset during WAKE restarts the settle window
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0);
        expect3("gated before wake", 0, 0, 1);
        cycle(0, 1, 0, 0);
        expect3("wake entry", 1, 0, 0);
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        expect3("reset in wake", 1, 0, 0);
        cycle(0, 1, 0, 0);
        expect3("post reset wake1", 1, 0, 0);
        cycle(0, 1, 0, 0);
        expect3("post reset wake2", 1, 1, 0);

`ifdef CLKGATE_STATS_EN
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        expect3("stats gated", 0, 0, 1);
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0);
        check("stats ten", int'(gated_cycles), 10);
        cycle(0, 0, 0, 1);
        check("stats clear", int'(gated_cycles), 0);
        for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
        check("stats saturate", int'(gated_cycles), 15);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 59) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
